// File: rtl/reg_file_sb.sv
// reg_file_sb: ID-stage register file with two combinational read ports,
// one WB write port, write->read bypass, branch-equality output and a
// per-register busy scoreboard for the hazard unit.

// One architectural register plus its busy bit.
module reg_file_sb_entry #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_hit,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_hit,
    input  logic              flush,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    // Data storage: a write lands one cycle after wr_en is seen.
    always_ff @(posedge clk) begin
        if (rst)
            data <= '0;
        else if (wr_hit)
            data <= wr_data;
    end

    // Busy bit: a new issue beats a retiring write to the same register,
    // because the issued instruction is the newer producer.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= 1'b0;
        else if (flush)
            busy <= 1'b0;
        else if (iss_hit)
            busy <= 1'b1;
        else if (wr_hit)
            busy <= 1'b0;
    end
endmodule

module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              equal,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic              busy1,
    output logic              busy2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            // Hardwired zero register: never written, never busy.
            assign regs[i] = '0;
            assign busy[i] = 1'b0;
        end else begin : g_reg
            reg_file_sb_entry #(.DATA_W(DATA_W)) u_ent (
                .clk     (clk),
                .rst     (rst),
                .wr_hit  (wr_en && (wr_addr == ADDR_W'(i))),
                .wr_data (wr_data),
                .iss_hit (issue_en && (issue_addr == ADDR_W'(i))),
                .flush   (flush),
                .data    (regs[i]),
                .busy    (busy[i])
            );
        end
    end

    // Read mux shared by both ports: zero register first, then the
    // in-flight write, then stored contents.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0]            a,
        input logic [DEPTH-1:0][DATA_W-1:0] r,
        input logic                         we,
        input logic [ADDR_W-1:0]            wa,
        input logic [DATA_W-1:0]            wd
    );
        logic [DATA_W-1:0] v;
        if (ZERO_REG != 0 && a == '0)
            v = '0;
        else if (BYPASS != 0 && we && wa == a)
            v = wd;
        else
            v = r[a];
        return v;
    endfunction

    // Hazard flag: a write retiring this cycle resolves the hazard at once,
    // since the bypass already delivers its value.
    function automatic logic busy_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DEPTH-1:0]  b,
        input logic              we,
        input logic [ADDR_W-1:0] wa
    );
        return b[a] && !(BYPASS != 0 && we && wa == a);
    endfunction

    // Combinational read ports, branch compare and hazard outputs.
    always_comb begin
        rd_data1 = rd_sel(rd_addr1, regs, wr_en, wr_addr, wr_data);
        rd_data2 = rd_sel(rd_addr2, regs, wr_en, wr_addr, wr_data);
        equal    = (rd_data1 == rd_data2);
        busy1    = busy_sel(rd_addr1, busy, wr_en, wr_addr);
        busy2    = busy_sel(rd_addr2, busy, wr_en, wr_addr);
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed test of reg_file_sb (32x32, ZERO_REG=1, BYPASS=1).
// Each step drives inputs after a falling edge, pushes the expected outputs
// to a scoreboard queue, then pops and compares them before the next rise.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic [31:0] rd_data1, rd_data2, wr_data;
    logic        equal, wr_en, issue_en, flush, busy1, busy2;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        eq;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    reg_file_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .equal      (equal),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy1      (busy1),
        .busy2      (busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic fl);
        rd_addr1 = a1; rd_addr2 = a2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia; flush = fl;
    endtask

    // Drive one cycle of stimulus, push expectation, compare before the rise.
    task automatic step(input string tag,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia, input logic fl,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic eq, input logic b1, input logic b2);
        exp_t e;
        drive(a1, a2, we, wa, wd, ie, ia, fl);
        sb_q.push_back('{rd1: e1, rd2: e2, eq: eq, b1: b1, b2: b2});
        #2;
        e = sb_q.pop_front();
        chk({tag, ".rd1"},  rd_data1,       e.rd1);
        chk({tag, ".rd2"},  rd_data2,       e.rd2);
        chk({tag, ".eq"},   {31'd0, equal}, {31'd0, e.eq});
        chk({tag, ".b1"},   {31'd0, busy1}, {31'd0, e.b1});
        chk({tag, ".b2"},   {31'd0, busy2}, {31'd0, e.b2});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state across every address; writes/issues during reset ignored.
        for (int a = 0; a < 32; a++)
            step("rst", 5'(a), 5'(31 - a), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Write r5 with same-cycle bypass, then stored value.
        step("wr5_byp", 5, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0);
        step("wr5_rd",  5, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);

        // Zero register ignores writes, issues and bypass.
        step("r0_wr",   0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 1, 0, 0);
        step("r0_iss",  0, 5, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        step("r0_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Issue r7, then write resolves hazard combinationally.
        step("r7_iss",  7, 5, 0, 0, 0, 1, 7, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        step("r7_busy", 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step("r7_wr",   7, 7, 1, 7, 32'h55, 0, 0, 0, 32'h55, 32'h55, 1, 0, 0);
        step("r7_done", 7, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0, 0);

        // Issue and write r3 together: data lands, busy stays set.
        step("r3_both", 3, 4, 1, 3, 32'h9, 1, 3, 0, 32'h9, 0, 0, 0, 0);
        step("r4_iss",  3, 4, 0, 0, 0, 1, 4, 0, 32'h9, 0, 0, 1, 0);
        step("flush",   3, 4, 0, 0, 0, 1, 6, 1, 32'h9, 0, 0, 1, 1);
        step("post_fl", 3, 6, 0, 0, 0, 0, 0, 0, 32'h9, 0, 0, 0, 0);
        step("post_f4", 4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Branch compare follows bypassed values.
        step("eq_w1",   1, 2, 1, 1, 32'hA, 0, 0, 0, 32'hA, 0, 0, 0, 0);
        step("eq_w2",   1, 2, 1, 2, 32'hA, 0, 0, 0, 32'hA, 32'hA, 1, 0, 0);
        step("eq_same", 1, 2, 0, 0, 0, 0, 0, 0, 32'hA, 32'hA, 1, 0, 0);
        step("eq_byp",  1, 2, 1, 2, 32'hB, 0, 0, 0, 32'hA, 32'hB, 0, 0, 0);
        step("eq_hold", 1, 2, 0, 0, 0, 0, 0, 0, 32'hA, 32'hB, 0, 0, 0);

        // Write to a busy register from the other port, leaving others busy.
        step("r9_iss",  9, 10, 0, 0, 0, 1, 9, 0, 0, 0, 1, 0, 0);
        step("r10_iss", 9, 10, 0, 0, 0, 1, 10, 0, 0, 0, 1, 1, 0);
        step("r9_wr",   9, 10, 1, 9, 32'h77, 0, 0, 0, 32'h77, 0, 0, 0, 1);

        // Mid-sequence reset discards data and busy; concurrent ops ignored.
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b1, 5'd1, 32'hFF, 1'b1, 5'd11, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("rst2_a", 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rst2_b", 9, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rst2_c", 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
